// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, ALUOp control values and Funct3 constants
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_SUB = 4'b0001,
        OP_ADD = 4'b0010,
        OP_BNE = 4'b0011,
        OP_OR  = 4'b0100,
        OP_XOR = 4'b0101,
        OP_BGE = 4'b0110,
        OP_BLT = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_NOP = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        CTRL_ADDR   = 2'b00,
        CTRL_BRANCH = 2'b01,
        CTRL_RTYPE  = 2'b10,
        CTRL_ITYPE  = 2'b11
    } alu_ctrl_e;

    // Branch funct3 values
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // Arithmetic/logic funct3 values
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - combinational ALUOp/Funct3/Funct7[5] to ALU op decode
//   alu_op_i   : ALUOp control class
//   funct3_i   : instruction funct3
//   funct7_5_i : instruction funct7 bit 5 (selects SUB for R-type)
//   op_o       : ALU operation, NOP for unsupported encodings
//   illegal_o  : high when the encoding is unsupported
module alu_op_decoder
    import alu_pkg::*;
(
    input  alu_ctrl_e  alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output alu_op_e    op_o,
    output logic       illegal_o
);

    always_comb begin
        op_o      = OP_NOP;
        illegal_o = 1'b1;
        unique case (alu_op_i)
            CTRL_ADDR: begin
                op_o      = OP_ADD;
                illegal_o = 1'b0;
            end
            CTRL_BRANCH: begin
                illegal_o = 1'b0;
                case (funct3_i)
                    F3_BEQ:  op_o = OP_EQ;
                    F3_BNE:  op_o = OP_BNE;
                    F3_BLT:  op_o = OP_BLT;
                    F3_BGE:  op_o = OP_BGE;
                    default: illegal_o = 1'b1;
                endcase
            end
            CTRL_RTYPE, CTRL_ITYPE: begin
                illegal_o = 1'b0;
                case (funct3_i)
                    // Funct7[5] only distinguishes SUB for register ops; ADDI
                    // immediates can legitimately carry that bit set.
                    F3_ADD:  op_o = (alu_op_i == CTRL_RTYPE && funct7_5_i) ? OP_SUB : OP_ADD;
                    F3_AND:  op_o = OP_AND;
                    F3_OR:   op_o = OP_OR;
                    F3_XOR:  op_o = OP_XOR;
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue register with ALU decode, SrcB mux and illegal-op counter
//   clk, reset          : clock, synchronous active-high reset
//   id_valid            : ID holds a valid instruction
//   stall, flush        : hold EX register / insert bubble (flush wins)
//   ALUOp, Funct3,
//   Funct7, ALUSrc      : decode controls
//   RegA, RegB, Imm     : operand sources
//   ex_valid, Operation,
//   SrcA, SrcB,
//   ex_illegal          : registered EX-stage outputs
//   illegal_count       : saturating count of accepted illegal ops
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     ALUSrc,
    input  logic [DATA_WIDTH-1:0]    RegA,
    input  logic [DATA_WIDTH-1:0]    RegB,
    input  logic [DATA_WIDTH-1:0]    Imm,
    output logic                     ex_valid,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     ex_illegal,
    output logic [CNT_WIDTH-1:0]     illegal_count
);

    alu_op_e dec_op;
    logic    dec_illegal;
    logic    unused_funct7;

    assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

    alu_op_decoder u_decoder (
        .alu_op_i   (alu_ctrl_e'(ALUOp)),
        .funct3_i   (Funct3),
        .funct7_5_i (Funct7[5]),
        .op_o       (dec_op),
        .illegal_o  (dec_illegal)
    );

    logic                  valid_q,   valid_d;
    alu_op_e               op_q,      op_d;
    logic [DATA_WIDTH-1:0] src_a_q,   src_a_d;
    logic [DATA_WIDTH-1:0] src_b_q,   src_b_d;
    logic                  illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0]  count_q,   count_d;

    always_comb begin
        valid_d   = valid_q;
        op_d      = op_q;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        if (flush || (!stall && !id_valid)) begin
            // Flush and an empty ID slot both load the same bubble.
            valid_d   = 1'b0;
            op_d      = OP_NOP;
            src_a_d   = '0;
            src_b_d   = '0;
            illegal_d = 1'b0;
        end else if (!stall) begin
            valid_d   = 1'b1;
            op_d      = dec_op;
            src_a_d   = RegA;
            src_b_d   = ALUSrc ? Imm : RegB;
            illegal_d = dec_illegal;
            if (dec_illegal && (count_q != {CNT_WIDTH{1'b1}})) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            op_q      <= OP_NOP;
            src_a_q   <= '0;
            src_b_q   <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            op_q      <= op_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign ex_valid      = valid_q;
    assign Operation     = OPCODE_LENGTH'(op_q);
    assign SrcA          = src_a_q;
    assign SrcB          = src_b_q;
    assign ex_illegal    = illegal_q;
    assign illegal_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        stall;
    logic        flush;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic        ALUSrc;
    logic [31:0] RegA;
    logic [31:0] RegB;
    logic [31:0] Imm;
    logic        ex_valid;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        ex_illegal;
    logic [7:0]  illegal_count;

    int errors = 0;
    int checks = 0;

    // Reference state
    int          m_valid;
    int          m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_ill;
    int          m_cnt;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .stall         (stall),
        .flush         (flush),
        .ALUOp         (ALUOp),
        .Funct3        (Funct3),
        .Funct7        (Funct7),
        .ALUSrc        (ALUSrc),
        .RegA          (RegA),
        .RegB          (RegB),
        .Imm           (Imm),
        .ex_valid      (ex_valid),
        .Operation     (Operation),
        .SrcA          (SrcA),
        .SrcB          (SrcB),
        .ex_illegal    (ex_illegal),
        .illegal_count (illegal_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns op code, or -1 for an unsupported encoding.
    function automatic int ref_decode(int aluop, int f3, int f7);
        int bit5 = (f7 >> 5) & 1;
        if (aluop == 0) return 2;
        if (aluop == 1) begin
            if (f3 == 0) return 8;
            if (f3 == 1) return 3;
            if (f3 == 4) return 7;
            if (f3 == 5) return 6;
            return -1;
        end
        if (f3 == 0) return (aluop == 2 && bit5 == 1) ? 1 : 2;
        if (f3 == 7) return 0;
        if (f3 == 6) return 4;
        if (f3 == 4) return 5;
        return -1;
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_op = 15; m_a = 0; m_b = 0; m_ill = 0;
    endtask

    task automatic model_edge();
        int op;
        if (reset) begin
            model_bubble();
            m_cnt = 0;
        end else if (flush) begin
            model_bubble();
        end else if (!stall) begin
            if (!id_valid) begin
                model_bubble();
            end else begin
                op      = ref_decode(int'(ALUOp), int'(Funct3), int'(Funct7));
                m_valid = 1;
                m_op    = (op < 0) ? 15 : op;
                m_ill   = (op < 0) ? 1 : 0;
                m_a     = RegA;
                m_b     = ALUSrc ? Imm : RegB;
                if (op < 0 && m_cnt < 255) m_cnt++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, 64'(ex_valid), 64'(m_valid));
        check({tag, ".op"},    64'(Operation), 64'(m_op));
        check({tag, ".srca"},  64'(SrcA), 64'(m_a));
        check({tag, ".srcb"},  64'(SrcB), 64'(m_b));
        check({tag, ".ill"},   64'(ex_illegal), 64'(m_ill));
        check({tag, ".cnt"},   64'(illegal_count), 64'(m_cnt));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic set_op(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7);
        id_valid = 1'b1; ALUOp = aop; Funct3 = f3; Funct7 = f7;
    endtask

    task automatic randomize_ops();
        id_valid = ($urandom_range(0, 5) != 0);
        ALUOp    = 2'($urandom_range(0, 3));
        Funct3   = 3'($urandom_range(0, 7));
        Funct7   = 7'($urandom);
        ALUSrc   = 1'($urandom);
        RegA     = $urandom;
        RegB     = $urandom;
        Imm      = $urandom;
    endtask

    initial begin
        logic [2:0] br_f3 [5];
        logic [3:0] br_op [5];
        br_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010};
        br_op = '{4'b1000, 4'b0011, 4'b0111, 4'b0110, 4'b1111};

        reset = 1'b1; id_valid = 0; stall = 0; flush = 0;
        ALUOp = 0; Funct3 = 0; Funct7 = 0; ALUSrc = 0; RegA = 0; RegB = 0; Imm = 0;
        m_cnt = 0; model_bubble();
        #2;
        step("reset");
        check("reset.op_nop", 64'(Operation), 64'hF);
        reset = 1'b0;

        // 1: R-type SUB
        set_op(2'b10, 3'b000, 7'b0100000); ALUSrc = 0; RegA = 7; RegB = 3;
        step("t1");
        check("t1.sub", 64'(Operation), 64'h1);
        check("t1.b",   64'(SrcB), 64'h3);

        // 2: I-type ADDI ignores Funct7
        set_op(2'b11, 3'b000, 7'b0100000); ALUSrc = 1; Imm = 32'hFFFF_FFFF;
        step("t2");
        check("t2.add", 64'(Operation), 64'h2);
        check("t2.imm", 64'(SrcB), 64'hFFFF_FFFF);

        // 3: branch sweep
        ALUSrc = 0;
        for (int i = 0; i < 5; i++) begin
            set_op(2'b01, br_f3[i], 7'd0);
            step("t3");
            check("t3.br", 64'(Operation), 64'(br_op[i]));
        end
        check("t3.cnt", 64'(illegal_count), 64'd1);

        // 4: hold AND under stall
        set_op(2'b10, 3'b111, 7'd0); RegA = 32'h55; RegB = 32'hAA;
        step("t4.load");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_ops();
            step("t4.stall");
            check("t4.hold", 64'(Operation), 64'h0);
        end
        stall = 0; set_op(2'b00, 3'b010, 7'd0);
        step("t4.release");
        check("t4.next", 64'(Operation), 64'h2);

        // 5: stall and flush together
        stall = 1; flush = 1;
        step("t5");
        check("t5.valid", 64'(ex_valid), 64'h0);
        check("t5.nop",   64'(Operation), 64'hF);
        stall = 0; flush = 0;

        // 6: saturation then reset
        set_op(2'b01, 3'b010, 7'd0);
        for (int i = 0; i < 300; i++) step("t6.sat");
        check("t6.cnt255", 64'(illegal_count), 64'd255);
        reset = 1;
        step("t6.reset");
        check("t6.cnt0", 64'(illegal_count), 64'd0);
        reset = 0;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            randomize_ops();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 63) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
